// File: rtl/gray_arb_pkg.sv
// Shared constants, state encoding and ID-width helper for the shared Gray encoder arbiter.
package gray_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    RESULT = 1'b1
  } state_e;

  // A single requester still needs a 1-bit ID field.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gray_encode.sv
// Purely combinational binary-to-Gray encoder; Gray MSB equals binary MSB.
module gray_encode #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one Gray encoder between NREQ requesters.
// Define GRAY_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority instead.
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [NREQ-1:0]             REQ,
  input  logic [NREQ*WIDTH-1:0]       BIN_IN,
  output logic [NREQ-1:0]             GNT,
  output logic [WIDTH-1:0]            GRAY_OUT,
  output logic [id_width(NREQ)-1:0]   OUT_ID,
  output logic                        OUT_VALID,
  input  logic                        OUT_RDY,
  output logic                        BUSY
);

  localparam int IDW = id_width(NREQ);

  // Handshake: a result transfers on the rising edge where OUT_VALID && OUT_RDY;
  // until then OUT_VALID, GRAY_OUT and OUT_ID stay stable. OUT_RDY while
  // OUT_VALID is low has no effect.

  state_e              state_q, state_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [WIDTH-1:0]    gray_q, gray_d;
  logic [IDW-1:0]      id_q, id_d;
  logic                valid_q, valid_d;

  logic                win_found;
  logic [IDW-1:0]      win_id;
  logic [WIDTH-1:0]    win_bin;
  logic [WIDTH-1:0]    win_gray;

`ifdef GRAY_ARB_FIXED_PRI_EN
  // Descending scan so the lowest set index is the final assignment.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (REQ[i]) begin
        win_found = 1'b1;
        win_id    = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] last_q, last_d;
  int             rr_idx;

  // Scan from LAST+NREQ down to LAST+1 so the first requester after LAST wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_idx    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      rr_idx = int'(last_q) + k;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      if (REQ[rr_idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(rr_idx);
      end
    end
  end
`endif

  assign win_bin = BIN_IN[int'(win_id)*WIDTH +: WIDTH];

  gray_encode #(.WIDTH(WIDTH)) u_gray_encode (
    .bin  (win_bin),
    .gray (win_gray)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    gray_d  = gray_q;
    id_d    = id_q;
    valid_d = valid_q;
`ifndef GRAY_ARB_FIXED_PRI_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d[win_id] = 1'b1;
          gray_d        = win_gray;
          id_d          = win_id;
          valid_d       = 1'b1;
`ifndef GRAY_ARB_FIXED_PRI_EN
          last_d        = win_id;
`endif
          state_d       = RESULT;
        end
      end
      RESULT: begin
        if (valid_q && OUT_RDY) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gray_q  <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
`ifndef GRAY_ARB_FIXED_PRI_EN
      last_q  <= IDW'(NREQ - 1);
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gray_q  <= gray_d;
      id_q    <= id_d;
      valid_q <= valid_d;
`ifndef GRAY_ARB_FIXED_PRI_EN
      last_q  <= last_d;
`endif
    end
  end

  assign GNT       = gnt_q;
  assign GRAY_OUT  = gray_q;
  assign OUT_ID    = id_q;
  assign OUT_VALID = valid_q;
  assign BUSY      = (state_q != IDLE);

endmodule
